// File: rtl/subservient_periph_ctrl_pkg.sv
// Shared definitions for the subservient peripheral bus controller.
//   state_t          : controller FSM states (IDLE=0, BUSY=1, RESP=2)
//   DEFAULT_ERR_RDT  : read data returned when a slave never acknowledges
//   DEFAULT_NSLAVES  : default number of slave ports
//   DEFAULT_TIMEOUT  : default abort threshold in cycles
package subservient_periph_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_RDT = 32'hDEADBEEF;
  localparam int          DEFAULT_NSLAVES = 4;
  localparam int          DEFAULT_TIMEOUT = 255;
  localparam int          DATA_W          = 32;
  localparam int          SEL_W           = 4;

endpackage

// File: rtl/subservient_periph_ctrl_wb_timer.sv
// subservient_wb_timer: saturating up-counter used to bound how long a slave
// strobe may stay unanswered.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset, counter -> 0
//   i_clr  : synchronous clear (has priority over i_en)
//   i_en   : count one per cycle while high, stops at all-ones
//   o_tc   : high while the count equals TC (terminal count)
module subservient_wb_timer #(
  parameter int          TW = 8,
  parameter int unsigned TC = 254
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {TW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TW'(TC));

endmodule

// File: rtl/subservient_periph_ctrl.sv
// subservient_periph_ctrl: single-outstanding Wishbone peripheral controller.
// Decodes the slave from the top address bits, registers the request to the
// slaves, waits for the selected slave's ack and returns a one-cycle response.
// A slave that stays silent for TIMEOUT cycles is aborted with ERR_RDT and a
// sticky error flag that records the first failing address.
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   i_wb_adr/dat/sel/we/stb  : master request (stb held until o_wb_ack)
//   o_wb_rdt, o_wb_ack       : response (rdt is 0 outside the ack cycle)
//   o_s_adr/dat/sel/we       : registered request broadcast to all slaves
//   o_s_stb                  : one-hot strobe to the selected slave
//   i_s_rdt, i_s_ack         : slave read data (32 bits per slave) and acks
//   i_clr_err                : clears o_err and o_err_adr
//   o_err, o_err_adr         : sticky timeout flag and first timed-out address
module subservient_periph_ctrl
  import subservient_periph_ctrl_pkg::*;
#(
  parameter int          NSLAVES = DEFAULT_NSLAVES,
  parameter int          SW      = $clog2(NSLAVES),
  parameter int          TIMEOUT = DEFAULT_TIMEOUT,
  parameter int          TW      = $clog2(TIMEOUT + 1),
  parameter logic [31:0] ERR_RDT = DEFAULT_ERR_RDT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_W-1:0]       i_wb_adr,
  input  logic [DATA_W-1:0]       i_wb_dat,
  input  logic [SEL_W-1:0]        i_wb_sel,
  input  logic                    i_wb_we,
  input  logic                    i_wb_stb,
  output logic [DATA_W-1:0]       o_wb_rdt,
  output logic                    o_wb_ack,
  output logic [DATA_W-1:0]       o_s_adr,
  output logic [DATA_W-1:0]       o_s_dat,
  output logic [SEL_W-1:0]        o_s_sel,
  output logic                    o_s_we,
  output logic [NSLAVES-1:0]      o_s_stb,
  input  logic [32*NSLAVES-1:0]   i_s_rdt,
  input  logic [NSLAVES-1:0]      i_s_ack,
  input  logic                    i_clr_err,
  output logic                    o_err,
  output logic [DATA_W-1:0]       o_err_adr
);

  state_t              r_state;
  state_t              w_state_next;

  logic [DATA_W-1:0]   r_s_adr;
  logic [DATA_W-1:0]   r_s_dat;
  logic [SEL_W-1:0]    r_s_sel;
  logic                r_s_we;
  logic [NSLAVES-1:0]  r_s_stb;
  logic [SW-1:0]       r_idx;
  logic [DATA_W-1:0]   r_rdt;
  logic                r_err;
  logic [DATA_W-1:0]   r_err_adr;

  logic [SW-1:0]       w_idx;
  logic [NSLAVES-1:0]  w_onehot;
  logic [31:0]         w_s_rdt [NSLAVES];
  logic                w_accept;
  logic                w_busy;
  logic                w_sel_ack;
  logic                w_tc;
  logic                w_finish;
  logic                w_timeout;

  // Slave select comes from the top SW address bits.
  assign w_idx = i_wb_adr[31 -: SW];

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVES; gi++) begin : g_slave
      assign w_s_rdt[gi]  = i_s_rdt[32*gi +: 32];
      assign w_onehot[gi] = (w_idx == SW'(gi));
    end
  endgenerate

  assign w_busy    = (r_state == ST_BUSY);
  assign w_accept  = (r_state == ST_IDLE) && i_wb_stb;
  // Only the selected slave's ack counts, and only while BUSY.
  assign w_sel_ack = i_s_ack[r_idx];
  assign w_finish  = w_busy && (w_sel_ack || w_tc);
  // An ack on the terminal-count cycle is a normal completion, not a timeout.
  assign w_timeout = w_busy && !w_sel_ack && w_tc;

  // The counter is cleared when a request is accepted, so the first BUSY
  // cycle sees 0 and the strobe stays up for exactly TIMEOUT cycles.
  subservient_wb_timer #(
    .TW (TW),
    .TC (TIMEOUT - 1)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_accept),
    .i_en  (w_busy),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_wb_ack     = 1'b0;
    o_wb_rdt     = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_wb_stb) begin
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_sel_ack || w_tc) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        o_wb_ack     = 1'b1;
        o_wb_rdt     = r_rdt;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request registers and one-hot strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_adr <= '0;
      r_s_dat <= '0;
      r_s_sel <= '0;
      r_s_we  <= 1'b0;
      r_s_stb <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_s_adr <= i_wb_adr;
      r_s_dat <= i_wb_dat;
      r_s_sel <= i_wb_sel;
      r_s_we  <= i_wb_we;
      r_s_stb <= w_onehot;
      r_idx   <= w_idx;
    end else if (w_finish) begin
      r_s_stb <= '0;
    end
  end

  // Response data: writes always return 0; aborted reads return ERR_RDT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdt <= '0;
    end else if (w_finish) begin
      if (r_s_we) begin
        r_rdt <= '0;
      end else if (w_sel_ack) begin
        r_rdt <= w_s_rdt[r_idx];
      end else begin
        r_rdt <= ERR_RDT;
      end
    end
  end

  // Sticky error. A timeout beats a simultaneous clear, and in that case the
  // new address replaces the old one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err     <= 1'b0;
      r_err_adr <= '0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
      if (!r_err || i_clr_err) begin
        r_err_adr <= r_s_adr;
      end
    end else if (i_clr_err) begin
      r_err     <= 1'b0;
      r_err_adr <= '0;
    end
  end

  assign o_s_adr   = r_s_adr;
  assign o_s_dat   = r_s_dat;
  assign o_s_sel   = r_s_sel;
  assign o_s_we    = r_s_we;
  assign o_s_stb   = r_s_stb;
  assign o_err     = r_err;
  assign o_err_adr = r_err_adr;

endmodule

// File: tb/tb_subservient_periph_ctrl.sv
`timescale 1ns/1ps
module tb_subservient_periph_ctrl;

  localparam int          NS      = 4;
  localparam int          TMO     = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

  logic            clk;
  logic            i_rst;
  logic [31:0]     i_wb_adr, i_wb_dat;
  logic [3:0]      i_wb_sel;
  logic            i_wb_we, i_wb_stb;
  logic [31:0]     o_wb_rdt;
  logic            o_wb_ack;
  logic [31:0]     o_s_adr, o_s_dat;
  logic [3:0]      o_s_sel;
  logic            o_s_we;
  logic [NS-1:0]   o_s_stb;
  logic [32*NS-1:0] i_s_rdt;
  logic [NS-1:0]   i_s_ack;
  logic            i_clr_err;
  logic            o_err;
  logic [31:0]     o_err_adr;

  subservient_periph_ctrl #(
    .NSLAVES (NS),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .i_wb_sel  (i_wb_sel),
    .i_wb_we   (i_wb_we),
    .i_wb_stb  (i_wb_stb),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .o_s_adr   (o_s_adr),
    .o_s_dat   (o_s_dat),
    .o_s_sel   (o_s_sel),
    .o_s_we    (o_s_we),
    .o_s_stb   (o_s_stb),
    .i_s_rdt   (i_s_rdt),
    .i_s_ack   (i_s_ack),
    .i_clr_err (i_clr_err),
    .o_err     (o_err),
    .o_err_adr (o_err_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the current cycle, maintained by the stimulus.
  logic [NS-1:0] exp_stb;
  logic          exp_ack;
  logic [31:0]   exp_rdt, exp_adr, exp_dat;
  logic [3:0]    exp_sel;
  logic          exp_we;
  logic          m_err;
  logic [31:0]   m_err_adr;
  bit            chk_en;
  int            n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_ack",  32'(o_wb_ack), 32'(exp_ack));
      check("wb_rdt",  o_wb_rdt, exp_rdt);
      check("s_stb",   32'(o_s_stb), 32'(exp_stb));
      check("err",     32'(o_err), 32'(m_err));
      check("err_adr", o_err_adr, m_err_adr);
      if (exp_stb != '0) begin
        check("s_adr", o_s_adr, exp_adr);
        check("s_dat", o_s_dat, exp_dat);
        check("s_sel", 32'(o_s_sel), 32'(exp_sel));
        check("s_we",  32'(o_s_we), 32'(exp_we));
      end
    end
  end

  // Advance one clock edge and apply the sticky-error rules to the model.
  task automatic tick(input logic tmo_evt, input logic [31:0] a);
    logic clr_prev;
    clr_prev = i_clr_err;
    @(posedge clk); #1;
    if (tmo_evt) begin
      if (!m_err || clr_prev) m_err_adr = a;
      m_err = 1'b1;
    end else if (clr_prev) begin
      m_err     = 1'b0;
      m_err_adr = '0;
    end
  endtask

  task automatic idle(input int n, input int clr_rate);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, '0);
      exp_stb   = '0;
      exp_ack   = 1'b0;
      exp_rdt   = '0;
      i_wb_stb  = 1'b0;
      i_wb_adr  = $urandom;
      i_s_ack   = NS'($urandom);
      i_s_rdt   = {$urandom, $urandom, $urandom, $urandom};
      i_clr_err = (clr_rate > 0) ? ($urandom_range(0, clr_rate - 1) == 0) : 1'b0;
    end
  endtask

  // One master transaction. The selected slave acks in its w-th strobe
  // cycle; w > TMO means it stays silent and the controller must abort.
  task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input int w,
                        input logic [31:0] srdt, input bit noise,
                        input int clr_rate, input int clr_at, input int abort_rel,
                        output logic [31:0] got_rdt, output int got_stb,
                        output int got_ack);
    int            idx, len, ab;
    logic          tmo;
    logic [NS-1:0] oh, ack_v;
    logic [31:0]   exp_r;
    logic [32*NS-1:0] rv;
    got_rdt = '0;
    got_stb = 0;
    got_ack = 0;
    idx   = int'(adr[31:30]);
    oh    = NS'(1) << idx;
    tmo   = (w > TMO);
    len   = tmo ? TMO : w;
    exp_r = we ? 32'h0 : (tmo ? ERR_VAL : srdt);
    ab    = (abort_rel > len) ? len : abort_rel;
    // cycle 0: request presented to an idle controller
    i_wb_adr  = adr;
    i_wb_dat  = dat;
    i_wb_sel  = sel;
    i_wb_we   = we;
    i_wb_stb  = 1'b1;
    i_s_ack   = NS'($urandom);
    i_s_rdt   = {$urandom, $urandom, $urandom, $urandom};
    i_clr_err = (clr_at == 0) ? 1'b1 :
                (clr_rate > 0) ? ($urandom_range(0, clr_rate - 1) == 0) : 1'b0;
    for (int rel = 1; rel <= len + 1; rel++) begin
      tick(tmo && (rel == len + 1), adr);
      exp_stb = (rel <= len) ? oh : '0;
      exp_ack = (rel == len + 1);
      exp_rdt = exp_ack ? exp_r : 32'h0;
      exp_adr = adr;
      exp_dat = dat;
      exp_sel = sel;
      exp_we  = we;
      if (o_s_stb != '0) got_stb++;
      if (o_wb_ack) begin
        got_ack = rel;
        got_rdt = o_wb_rdt;
      end
      if (noise) begin
        i_wb_adr = $urandom;
        i_wb_dat = $urandom;
        i_wb_sel = 4'($urandom);
        i_wb_we  = 1'($urandom);
      end
      ack_v = noise ? (NS'($urandom) & ~oh) : '0;
      if (rel == w) ack_v = ack_v | oh;
      if (noise && rel == len + 1 && $urandom_range(0, 1) == 1) ack_v = ack_v | oh;
      i_s_ack = ack_v;
      rv = {$urandom, $urandom, $urandom, $urandom};
      if (rel == w) rv[32*idx +: 32] = srdt;
      i_s_rdt   = rv;
      i_clr_err = (clr_at == rel) ? 1'b1 :
                  (clr_rate > 0) ? ($urandom_range(0, clr_rate - 1) == 0) : 1'b0;
      if (rel == ab) begin
        #2;
        i_rst     = 1'b1;
        m_err     = 1'b0;
        m_err_adr = '0;
        exp_stb   = '0;
        exp_ack   = 1'b0;
        exp_rdt   = '0;
        #1;
        check("abort_stb", 32'(o_s_stb), 32'h0);
        check("abort_ack", 32'(o_wb_ack), 32'h0);
        @(posedge clk); #1;
        i_rst     = 1'b0;
        i_wb_stb  = 1'b0;
        i_s_ack   = '0;
        i_clr_err = 1'b0;
        $display("txn adr=%h we=%b wait=%0d reset at cycle %0d", adr, we, w, ab);
        return;
      end
    end
    idle(1, clr_rate);
    $display("txn adr=%h we=%b wait=%0d stb_cycles=%0d ack_cycle=%0d rdt=%h",
             adr, we, w, got_stb, got_ack, got_rdt);
  endtask

  logic [31:0] r;
  int          c, a;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    chk_en    = 0;
    i_rst     = 1'b1;
    i_wb_adr  = '0;
    i_wb_dat  = '0;
    i_wb_sel  = '0;
    i_wb_we   = 1'b0;
    i_wb_stb  = 1'b0;
    i_s_rdt   = '0;
    i_s_ack   = '0;
    i_clr_err = 1'b0;
    exp_stb   = '0;
    exp_ack   = 1'b0;
    exp_rdt   = '0;
    exp_adr   = '0;
    exp_dat   = '0;
    exp_sel   = '0;
    exp_we    = 1'b0;
    m_err     = 1'b0;
    m_err_adr = '0;
    #1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_stb",     32'(o_s_stb), 32'h0);
    check("rst_ack",     32'(o_wb_ack), 32'h0);
    check("rst_rdt",     o_wb_rdt, 32'h0);
    check("rst_err",     32'(o_err), 32'h0);
    check("rst_err_adr", o_err_adr, 32'h0);
    check("rst_s_adr",   o_s_adr, 32'h0);
    idle(2, 0);

    // GPIO write, immediate ack
    do_txn(32'h0000_0000, 32'h1, 4'hF, 1'b1, 1, 32'h1234_5678, 0, 0, -1, 0, r, c, a);
    check("t1_rdt", r, 32'h0);
    check("t1_stb_cycles", c, 1);
    check("t1_ack_cycle", a, 2);

    // SPI read, ack after 5 strobe cycles
    do_txn(32'h4000_0010, 32'h0, 4'hF, 1'b0, 5, 32'h0000_00A5, 0, 0, -1, 0, r, c, a);
    check("t2_rdt", r, 32'h0000_00A5);
    check("t2_stb_cycles", c, 5);
    check("t2_ack_cycle", a, 6);

    // silent slave 3 -> abort
    do_txn(32'hC000_0000, 32'h0, 4'hF, 1'b0, 50, 32'h0, 0, 0, -1, 0, r, c, a);
    check("t3_rdt", r, 32'hDEADBEEF);
    check("t3_stb_cycles", c, 8);
    check("t3_ack_cycle", a, 9);
    check("t3_err", 32'(o_err), 32'h1);
    check("t3_err_adr", o_err_adr, 32'hC000_0000);

    // second timeout keeps first address; then clear
    do_txn(32'h8000_0004, 32'h0, 4'hF, 1'b0, 50, 32'h0, 0, 0, -1, 0, r, c, a);
    check("t4_err_adr_sticky", o_err_adr, 32'hC000_0000);
    i_clr_err = 1'b1;
    idle(1, 0);
    check("t4_err_clr", 32'(o_err), 32'h0);
    check("t4_err_adr_clr", o_err_adr, 32'h0);

    // stray acks on other slaves are ignored
    do_txn(32'h4000_0000, 32'h0, 4'hF, 1'b0, 3, 32'h5A5A_1234, 1, 0, -1, 0, r, c, a);
    check("t5_stray_rdt", r, 32'h5A5A_1234);
    check("t5_stray_stb", c, 3);
    // ack on the terminal-count cycle wins
    do_txn(32'h4000_0020, 32'h0, 4'hF, 1'b0, 8, 32'h0BAD_F00D, 1, 0, -1, 0, r, c, a);
    check("t5_race_rdt", r, 32'h0BAD_F00D);
    check("t5_race_err", 32'(o_err), 32'h0);

    // clear on the same cycle as a new timeout: the new timeout wins
    do_txn(32'h8000_0000, 32'h0, 4'hF, 1'b0, 50, 32'h0, 0, 0, -1, 0, r, c, a);
    do_txn(32'hC000_0008, 32'h0, 4'hF, 1'b1, 50, 32'h0, 0, 0, 8, 0, r, c, a);
    check("t5_clr_race_err", 32'(o_err), 32'h1);
    check("t5_clr_race_adr", o_err_adr, 32'hC000_0008);
    check("t5_wr_tmo_rdt", r, 32'h0);

    // reset mid-BUSY, then a normal request
    do_txn(32'h4000_0000, 32'h0, 4'hF, 1'b0, 5, 32'h1111_2222, 0, 0, -1, 3, r, c, a);
    check("t6_no_ack", a, 0);
    idle(2, 0);
    do_txn(32'h0000_0008, 32'h7, 4'h3, 1'b1, 2, 32'h0, 0, 0, -1, 0, r, c, a);
    check("t6_after_rdt", r, 32'h0);
    check("t6_after_ack", a, 3);

    // randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ra;
      int          rw, ab;
      ra = $urandom;
      rw = $urandom_range(1, TMO + 3);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, TMO) : 0;
      do_txn(ra, $urandom, 4'($urandom), 1'($urandom), rw, $urandom,
             1, 10, -1, ab, r, c, a);
      idle($urandom_range(0, 2), 10);
    end

    idle(2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
